// File: rtl/processor_controller_pkg.sv
// proc_pkg: shared widths, opcodes, state encoding and ALU selects for processor_controller
// Optional feature macro PROC_JMPZ_EN (conditional-jump opcode).
package proc_pkg;

    localparam int INSTR_W   = 16;
    localparam int D_ADDR_W  = 8;
    localparam int RF_ADDR_W = 4;
    localparam int PC_W      = 5;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JMPZ  = 4'd6;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9,
        S_JMPZ   = 4'd10
    } state_t;

endpackage

// File: rtl/processor_controller_if.sv
// processor_controller_if: controller <-> PC/ROM/datapath bundle
// master = controller (drives pc/memory/rf/alu controls, receives instr_data),
// slave = environment. PROC_JMPZ_EN adds rf_ra_zero, pc_ld, pc_jaddr.
interface processor_controller_if;
    import proc_pkg::*;
    logic [INSTR_W-1:0]   instr_data;
    logic                 pc_clr;
    logic                 pc_up;
    logic [D_ADDR_W-1:0]  d_addr;
    logic                 d_wr;
    logic                 rf_s;
    logic [RF_ADDR_W-1:0] rf_w_addr;
    logic                 rf_w_wr;
    logic [RF_ADDR_W-1:0] rf_ra_addr;
    logic [RF_ADDR_W-1:0] rf_rb_addr;
    logic                 rf_ra_rd;
    logic                 rf_rb_rd;
    logic [2:0]           alu_s0;
    logic [3:0]           state_out;
`ifdef PROC_JMPZ_EN
    logic                 rf_ra_zero;
    logic                 pc_ld;
    logic [PC_W-1:0]      pc_jaddr;
`endif

    modport master (
        input  instr_data,
`ifdef PROC_JMPZ_EN
        input  rf_ra_zero,
        output pc_ld, pc_jaddr,
`endif
        output pc_clr, pc_up, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
               rf_ra_addr, rf_rb_addr, rf_ra_rd, rf_rb_rd, alu_s0, state_out
    );

    modport slave (
        output instr_data,
`ifdef PROC_JMPZ_EN
        output rf_ra_zero,
        input  pc_ld, pc_jaddr,
`endif
        input  pc_clr, pc_up, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
               rf_ra_addr, rf_rb_addr, rf_ra_rd, rf_rb_rd, alu_s0, state_out
    );
endinterface

// File: rtl/processor_controller_instruction_register.sv
// instruction_register: W-bit register with synchronous clear and load enable
// Ports: clock, clear (sync active-high), load, d in; q out.
module instruction_register #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock)
        q <= clear ? '0 : load ? d : q;
endmodule

// File: rtl/processor_controller.sv
// processor_controller: fetch/decode/execute sequencer driving PC, data memory, RF and ALU
// Ports: clock, clear (sync active-high reset); bus (processor_controller_if.master).
// Optional feature macro PROC_JMPZ_EN enables the JMPZ opcode and its ports.
module processor_controller
    import proc_pkg::*;
(
    input  logic                   clock,
    input  logic                   clear,
    processor_controller_if.master bus
);
    state_t state, next;
    logic [INSTR_W-1:0] ir;
    logic is_load, is_alu, is_store, is_jmpz;

    function automatic state_t decode(input logic [3:0] op);
        case (op)
            OP_STORE: return S_STORE;
            OP_LOAD:  return S_LOAD_A;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_HALT:  return S_HALT;
`ifdef PROC_JMPZ_EN
            OP_JMPZ:  return S_JMPZ;
`endif
            default:  return S_NOOP;
        endcase
    endfunction

    instruction_register #(.W(INSTR_W)) u_ir (
        .clock (clock),
        .clear (clear),
        .load  (state == S_FETCH),
        .d     (bus.instr_data),
        .q     (ir)
    );

    always_ff @(posedge clock)
        state <= clear ? S_INIT : next;

    always_comb begin
        next = state;
        case (state)
            S_INIT:   next = S_FETCH;
            S_FETCH:  next = S_DECODE;
            S_DECODE: next = decode(ir[15:12]);
            S_LOAD_A: next = S_LOAD_B;
            S_HALT:   next = S_HALT;
            default:  next = S_FETCH;
        endcase
    end

    // Moore decodes of state and IR; every output idles at 0
    always_comb begin
        is_load        = (state == S_LOAD_A) || (state == S_LOAD_B);
        is_alu         = (state == S_ADD) || (state == S_SUB);
        is_store       = state == S_STORE;
        is_jmpz        = state == S_JMPZ;
        bus.pc_clr     = state == S_INIT;
        bus.pc_up      = state == S_FETCH;
        bus.d_addr     = is_load ? ir[11:4] : is_store ? ir[7:0] : '0;
        bus.d_wr       = is_store;
        bus.rf_s       = is_load;
        bus.rf_w_addr  = (is_load || is_alu) ? ir[3:0] : '0;
        bus.rf_w_wr    = (state == S_LOAD_B) || is_alu;
        bus.rf_ra_addr = (is_store || is_alu || is_jmpz) ? ir[11:8] : '0;
        bus.rf_ra_rd   = is_store || is_alu || is_jmpz;
        bus.rf_rb_addr = is_alu ? ir[7:4] : '0;
        bus.rf_rb_rd   = is_alu;
        bus.alu_s0     = (state == S_ADD) ? ALU_ADD : (state == S_SUB) ? ALU_SUB : ALU_PASS;
        bus.state_out  = state;
`ifdef PROC_JMPZ_EN
        bus.pc_jaddr   = is_jmpz ? ir[PC_W-1:0] : '0;
        bus.pc_ld      = is_jmpz && bus.rf_ra_zero;
`endif
    end
endmodule

// File: tb/tb_processor_controller.sv
// tb_processor_controller: directed self-checking bench for processor_controller
module tb_processor_controller;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int checks = 0;
    int errors = 0;

    processor_controller_if bus ();

    processor_controller dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] others();
        return {3'b0, bus.pc_up, bus.d_addr, bus.d_wr, bus.rf_s, bus.rf_w_addr, bus.rf_w_wr,
                bus.rf_ra_addr, bus.rf_rb_addr, bus.rf_ra_rd, bus.rf_rb_rd, bus.alu_s0};
    endfunction

    initial begin
        bus.instr_data = 16'h2A53;
`ifdef PROC_JMPZ_EN
        bus.rf_ra_zero = 1'b0;
`endif
        step();
        step();
        chk("reset_state", 32'(bus.state_out), 0);
        chk("reset_pc_clr", 32'(bus.pc_clr), 1);
        chk("reset_others", others(), 0);
        clear = 1'b0;
        step();
        chk("fetch_state", 32'(bus.state_out), 1);
        chk("fetch_pc_up", 32'(bus.pc_up), 1);
        chk("fetch_pc_clr", 32'(bus.pc_clr), 0);
        step();
        chk("ld_decode_state", 32'(bus.state_out), 2);
        chk("ld_decode_outs", others(), 0);
        step();
        chk("ld_a_state", 32'(bus.state_out), 4);
        chk("ld_a_daddr", 32'(bus.d_addr), 32'hA5);
        chk("ld_a_rf_s", 32'(bus.rf_s), 1);
        chk("ld_a_waddr", 32'(bus.rf_w_addr), 3);
        chk("ld_a_wwr", 32'(bus.rf_w_wr), 0);
        chk("ld_a_pc_up", 32'(bus.pc_up), 0);
        step();
        chk("ld_b_state", 32'(bus.state_out), 5);
        chk("ld_b_daddr", 32'(bus.d_addr), 32'hA5);
        chk("ld_b_rf_s", 32'(bus.rf_s), 1);
        chk("ld_b_waddr", 32'(bus.rf_w_addr), 3);
        chk("ld_b_wwr", 32'(bus.rf_w_wr), 1);
        step();
        chk("ld_done_state", 32'(bus.state_out), 1);
        chk("ld_done_wwr", 32'(bus.rf_w_wr), 0);
        chk("add_fetch_pc_up", 32'(bus.pc_up), 1);
        bus.instr_data = 16'h3127;
        step();
        chk("add_decode_pc_up", 32'(bus.pc_up), 0);
        step();
        chk("add_state", 32'(bus.state_out), 7);
        chk("add_ra", 32'(bus.rf_ra_addr), 1);
        chk("add_rb", 32'(bus.rf_rb_addr), 2);
        chk("add_rw", 32'(bus.rf_w_addr), 7);
        chk("add_wwr", 32'(bus.rf_w_wr), 1);
        chk("add_rd", 32'({bus.rf_ra_rd, bus.rf_rb_rd}), 3);
        chk("add_rf_s", 32'(bus.rf_s), 0);
        chk("add_alu", 32'(bus.alu_s0), 1);
        chk("add_pc_up", 32'(bus.pc_up), 0);
        chk("add_dwr", 32'(bus.d_wr), 0);
        bus.instr_data = 16'h4127;
        step();
        chk("sub_fetch_pc_up", 32'(bus.pc_up), 1);
        step();
        step();
        chk("sub_state", 32'(bus.state_out), 8);
        chk("sub_ra", 32'(bus.rf_ra_addr), 1);
        chk("sub_rb", 32'(bus.rf_rb_addr), 2);
        chk("sub_rw", 32'(bus.rf_w_addr), 7);
        chk("sub_wwr", 32'(bus.rf_w_wr), 1);
        chk("sub_alu", 32'(bus.alu_s0), 2);
        chk("sub_pc_up", 32'(bus.pc_up), 0);
        bus.instr_data = 16'h1C40;
        step();
        chk("st_fetch_state", 32'(bus.state_out), 1);
        step();
        chk("st_decode_dwr", 32'(bus.d_wr), 0);
        step();
        chk("st_state", 32'(bus.state_out), 6);
        chk("st_daddr", 32'(bus.d_addr), 32'h40);
        chk("st_ra", 32'(bus.rf_ra_addr), 32'hC);
        chk("st_ra_rd", 32'(bus.rf_ra_rd), 1);
        chk("st_dwr", 32'(bus.d_wr), 1);
        chk("st_wwr", 32'(bus.rf_w_wr), 0);
        bus.instr_data = 16'hF123;
        step();
        chk("st_after_dwr", 32'(bus.d_wr), 0);
        step();
        step();
        chk("undef_state", 32'(bus.state_out), 3);
        chk("undef_outs", others(), 0);
        bus.instr_data = 16'h6215;
        step();
        chk("jz_fetch_state", 32'(bus.state_out), 1);
        step();
        step();
`ifdef PROC_JMPZ_EN
        chk("jz_state", 32'(bus.state_out), 10);
        chk("jz_ra", 32'(bus.rf_ra_addr), 2);
        chk("jz_ra_rd", 32'(bus.rf_ra_rd), 1);
        chk("jz_jaddr", 32'(bus.pc_jaddr), 32'h15);
        chk("jz_ld_zero0", 32'(bus.pc_ld), 0);
        bus.rf_ra_zero = 1'b1;
        #1;
        chk("jz_ld_zero1", 32'(bus.pc_ld), 1);
        bus.rf_ra_zero = 1'b0;
`else
        chk("jz_as_noop_state", 32'(bus.state_out), 3);
        chk("jz_as_noop_outs", others(), 0);
`endif
        bus.instr_data = 16'h5000;
        step();
        chk("halt_fetch_state", 32'(bus.state_out), 1);
        step();
        step();
        chk("halt_state", 32'(bus.state_out), 9);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_hold_state", 32'(bus.state_out), 9);
            chk("halt_hold_pc_up", 32'(bus.pc_up), 0);
        end
        clear = 1'b1;
        step();
        chk("halt_clear_state", 32'(bus.state_out), 0);
        chk("halt_clear_pc_clr", 32'(bus.pc_clr), 1);
        clear = 1'b0;
        bus.instr_data = 16'h3127;
        step();
        step();
        step();
        chk("mid_add_state", 32'(bus.state_out), 7);
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        chk("mid_rst_state", 32'(bus.state_out), 0);
        chk("mid_rst_pc_clr", 32'(bus.pc_clr), 1);
        chk("mid_rst_others", others(), 0);
        step();
        chk("mid_rst_fetch_state", 32'(bus.state_out), 1);
        chk("mid_rst_fetch_pc_up", 32'(bus.pc_up), 1);
        step();
        step();
        chk("post_rst_add_state", 32'(bus.state_out), 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
